shape_bag_generator: RTL

- Parametrised successor to the team's 5-bit LFSR shape source for the Tetris datapath.
- Generates tetromino IDs from a wide Galois LFSR using "7-bag" fairness: every group of NUM_SHAPES consecutive pieces contains each ID exactly once.
- Buffers the IDs in a small in-order queue, so the game FSM sees the current piece plus PREVIEW_DEPTH look-ahead pieces.
- Sits between the LFSR seed source and the game-control FSM / preview renderer.

---
 rtl/shape_pkg.sv | 38 +++
 rtl/shape_bag_generator_if.sv | 27 ++
 rtl/lfsr_galois.sv | 38 +++
 rtl/shape_bag_generator.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shape_pkg.sv
// Shared types and constants for the shape bag generator slice.
package shape_pkg;

  localparam int unsigned SHAPE_W = 3;

  typedef logic [SHAPE_W-1:0] shape_t;

  // Tetromino IDs
  localparam shape_t I = 3'd0;
  localparam shape_t O = 3'd1;
  localparam shape_t T = 3'd2;
  localparam shape_t S = 3'd3;
  localparam shape_t Z = 3'd4;
  localparam shape_t J = 3'd5;
  localparam shape_t L = 3'd6;

  typedef enum logic {
    ST_FILL,
    ST_READY
  } state_e;

  // Maximal-length right-shift Galois tap masks, bit (tap-1) set per tap.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hB400;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/shape_bag_generator_if.sv
// Request/response bundle between the seed/game FSM side and the generator.
interface shape_bag_generator_if
  import shape_pkg::*;
#(
  parameter int unsigned LFSR_W        = 16,
  parameter int unsigned PREVIEW_DEPTH = 3
) ();

  logic                               seed_load;
  logic [LFSR_W-1:0]                  seed_in;
  logic                               next_req;
  logic [SHAPE_W-1:0]                 shape_id;
  logic                               shape_valid;
  logic [SHAPE_W*PREVIEW_DEPTH-1:0]   preview;
  logic [3:0]                         bag_remaining;

  modport master (
    output seed_load, seed_in, next_req,
    input  shape_id, shape_valid, preview, bag_remaining
  );

  modport slave (
    input  seed_load, seed_in, next_req,
    output shape_id, shape_valid, preview, bag_remaining
  );

endinterface

// File: rtl/lfsr_galois.sv
// Right-shift Galois LFSR, free-running, with loadable seed and zero guard.
module lfsr_galois
  import shape_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAPS16    = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_T    = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_VAL = (SEED_T == '0) ? '1 : SEED_T;

  logic [WIDTH-1:0] state_q, state_d;

  // Next value: load (zero mapped to all-ones) or one Galois step
  always_comb begin
    state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    if (load) begin
      state_d = (load_val == '0) ? '1 : load_val;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RESET_VAL;
    else         state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/shape_bag_generator.sv
// Tetromino ID source: LFSR draw, optional 7-bag fairness, in-order
// look-ahead queue. Macro SHAPE_BAG_FAIRNESS_EN enables the bag; without it
// picks are the raw folded LFSR value and bag_remaining is constant.
module shape_bag_generator
  import shape_pkg::*;
#(
  parameter int unsigned LFSR_W        = 16,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned NUM_SHAPES    = 7,
  parameter int unsigned PREVIEW_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  shape_bag_generator_if.slave sb
);

  localparam int unsigned      QD    = PREVIEW_DEPTH + 1;
  localparam int unsigned      CNT_W = $clog2(QD + 1);
  localparam int unsigned      QW    = QD * SHAPE_W;
  localparam logic [CNT_W-1:0] QD_C  = CNT_W'(QD);
  localparam logic [3:0]       NS4   = 4'(NUM_SHAPES);
  localparam logic [2:0]       NS3   = 3'(NUM_SHAPES);

  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;
  shape_t            cand, pick;
  logic              pop, push;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, wr;
  logic [QW-1:0]     q_q, q_d;

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (sb.seed_load),
    .load_val (sb.seed_in),
    .state    (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:3];

  // Fold the low LFSR bits into 0..NUM_SHAPES-1
  always_comb begin
    cand = lfsr[2:0];
    if ({1'b0, lfsr[2:0]} >= NS4) cand = lfsr[2:0] - NS3;
  end

  assign pop  = sb.next_req && (state_q == ST_READY);
  assign push = (count_q < QD_C) || pop;

`ifdef SHAPE_BAG_FAIRNESS_EN
  logic [NUM_SHAPES-1:0] bag_q, bag_d, set_n;
  logic [7:0]            bag8;
  logic [3:0]            idx, drawn;
  logic                  found;

  assign bag8 = 8'(bag_q);

  // First ID not yet drawn, searching upward from cand with wrap
  always_comb begin
    pick  = cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SHAPES; i++) begin
      idx = {1'b0, cand} + 4'(i);
      if (idx >= NS4) idx = idx - NS4;
      if (!found && !bag8[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
  end

  // Mark the pushed ID; a completed bag clears in the same cycle
  always_comb begin
    set_n = bag_q | NUM_SHAPES'(8'b1 << pick);
    bag_d = bag_q;
    if (sb.seed_load) bag_d = '0;
    else if (push)    bag_d = (&set_n) ? '0 : set_n;
  end

  // Count IDs already drawn from the current bag
  always_comb begin
    drawn = '0;
    for (int unsigned i = 0; i < 8; i++) drawn = drawn + 4'(bag8[i[2:0]]);
  end

  assign sb.bag_remaining = NS4 - drawn;

  // Bag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) bag_q <= '0;
    else         bag_q <= bag_d;
  end
`else
  assign pick             = cand;
  assign sb.bag_remaining = NS4;
`endif

  // Queue shift/write and FILL/READY sequencing; seed_load flushes everything.
  // On pop+push the tail slot is count-1 after the shift, so count is unchanged.
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    state_d = state_q;
    wr      = pop ? (count_q - CNT_W'(1)) : count_q;
    if (sb.seed_load) begin
      q_d     = '0;
      count_d = '0;
      state_d = ST_FILL;
    end else begin
      if (pop)  q_d = q_q >> SHAPE_W;
      if (push) q_d[wr*SHAPE_W +: SHAPE_W] = pick;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        ST_FILL:  if (count_d == QD_C) state_d = ST_READY;
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_FILL;
      endcase
    end
  end

  // Queue, count and FSM registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q     <= '0;
      count_q <= '0;
      state_q <= ST_FILL;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Decode outputs from registers; empty slots read as zero
  always_comb begin
    sb.shape_id    = (count_q != '0) ? q_q[SHAPE_W-1:0] : '0;
    sb.shape_valid = (state_q == ST_READY);
    sb.preview     = '0;
    for (int unsigned k = 0; k < PREVIEW_DEPTH; k++) begin
      if (count_q > CNT_W'(k + 1))
        sb.preview[k*SHAPE_W +: SHAPE_W] = q_q[(k+1)*SHAPE_W +: SHAPE_W];
    end
  end

endmodule
